card_dealer: RTL and testbench

Draw engine for the BlackJack datapath: on a draw request it samples the free-running value from the game counter, maps it to an undealt card of a 52-card deck, and requests the counter's 2-second display hold. It then waits for the counter's two-second flag before presenting the card. It is the consumer side of the counter interface: it drives the zero and activate inputs and reads back the count and the two-second flag. It also tracks which cards are already out, so no card is dealt twice before a shuffle.

---
 rtl/card_dealer.sv | 135 +++++++++++++
 tb/tb_card_dealer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: deals undealt cards from a 52-card deck using the game counter as entropy,
// then holds each draw until the counter reports its two-second display window has elapsed.
module card_dealer #(
   parameter int WIDTH = 12
) (
   input  logic             clk_50M,
   input  logic             i_Reset,
   input  logic             i_Draw,
   input  logic             i_Shuffle,
   input  logic [WIDTH-1:0] i_Count,
   input  logic             i_TwoSec,
   output logic             o_Zero,
   output logic             o_Active,
   output logic             o_Busy,
   output logic             o_Valid,
   output logic [5:0]       o_Card,
   output logic [1:0]       o_Suit,
   output logic [3:0]       o_Rank,
   output logic [3:0]       o_Value,
   output logic [5:0]       o_Dealt,
   output logic             o_Empty
);
   typedef enum logic [2:0] {IDLE, SAMPLE, PROBE, ZERO, HOLD, DONE} state_t;
   state_t state_q, state_d;
   logic [51:0] mask_q, mask_d;
   logic [5:0] cand_q, cand_d, card_q, card_d, out_card_q, out_card_d, dealt_q, dealt_d, rem_c;
   logic [1:0] suit_q, suit_d;
   logic [3:0] rank_q, rank_d, value_q, value_d, rank_c, value_c;
   logic armed_q, armed_d, zero_q, zero_d, active_q, active_d, busy_q, busy_d;
   logic valid_q, valid_d, empty_q, empty_d;
   always_comb begin
      rem_c = card_q % 6'd13;
      rank_c = 4'(rem_c) + 4'd1;
      value_c = (rank_c == 4'd1) ? 4'd11 : (rank_c > 4'd10) ? 4'd10 : rank_c;
      state_d = state_q;
      mask_d = mask_q;
      cand_d = cand_q;
      card_d = card_q;
      out_card_d = out_card_q;
      suit_d = suit_q;
      rank_d = rank_q;
      value_d = value_q;
      dealt_d = dealt_q;
      empty_d = empty_q;
      // armed only from the second HOLD cycle, masking a stale flag from before the zero
      armed_d = (state_q == HOLD);
      case (state_q)
         IDLE: begin
            if (i_Shuffle) begin
               mask_d = '0;
               dealt_d = '0;
               empty_d = 1'b0;
            end else if (i_Draw && !empty_q) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            cand_d = 6'(i_Count % WIDTH'(52));
            state_d = PROBE;
         end
         PROBE: begin
            if (!mask_q[cand_q]) begin
               mask_d[cand_q] = 1'b1;
               card_d = cand_q;
               state_d = ZERO;
            end else begin
               cand_d = (cand_q == 6'd51) ? 6'd0 : cand_q + 6'd1;
            end
         end
         ZERO: state_d = HOLD;
         HOLD: begin
            if (armed_q && i_TwoSec) begin
               state_d = DONE;
               out_card_d = card_q;
               suit_d = 2'(card_q / 6'd13);
               rank_d = rank_c;
               value_d = value_c;
               dealt_d = dealt_q + 6'd1;
               empty_d = (dealt_q == 6'd51);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      zero_d = (state_d == ZERO);
      active_d = (state_d == HOLD);
      busy_d = (state_d != IDLE);
      valid_d = (state_d == DONE);
   end
   always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
         state_q <= IDLE;
         mask_q <= '0;
         cand_q <= '0;
         card_q <= '0;
         out_card_q <= '0;
         suit_q <= '0;
         rank_q <= '0;
         value_q <= '0;
         dealt_q <= '0;
         empty_q <= 1'b0;
         armed_q <= 1'b0;
         zero_q <= 1'b0;
         active_q <= 1'b0;
         busy_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q <= mask_d;
         cand_q <= cand_d;
         card_q <= card_d;
         out_card_q <= out_card_d;
         suit_q <= suit_d;
         rank_q <= rank_d;
         value_q <= value_d;
         dealt_q <= dealt_d;
         empty_q <= empty_d;
         armed_q <= armed_d;
         zero_q <= zero_d;
         active_q <= active_d;
         busy_q <= busy_d;
         valid_q <= valid_d;
      end
   end
   assign o_Zero = zero_q;
   assign o_Active = active_q;
   assign o_Busy = busy_q;
   assign o_Valid = valid_q;
   assign o_Card = out_card_q;
   assign o_Suit = suit_q;
   assign o_Rank = rank_q;
   assign o_Value = value_q;
   assign o_Dealt = dealt_q;
   assign o_Empty = empty_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized draws against a deck model, with a queue scoreboard checked by a monitor.
module tb_card_dealer;
   logic clk_50M = 1'b0, i_Reset = 1'b1, i_Draw = 1'b0, i_Shuffle = 1'b0, i_TwoSec = 1'b0;
   logic [11:0] i_Count = '0;
   logic o_Zero, o_Active, o_Busy, o_Valid, o_Empty;
   logic [5:0] o_Card, o_Dealt;
   logic [1:0] o_Suit;
   logic [3:0] o_Rank, o_Value;
   typedef struct {int card; int dealt; int zcyc; int vcyc;} exp_t;
   exp_t q[$];
   exp_t mon_e;
   bit deck[52];
   int ndealt = 0, cyc = 0, checks = 0, failures = 0;
   bit zseen = 0, prev_active = 0;

   card_dealer #(.WIDTH(12)) dut (
      .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Draw(i_Draw), .i_Shuffle(i_Shuffle),
      .i_Count(i_Count), .i_TwoSec(i_TwoSec), .o_Zero(o_Zero), .o_Active(o_Active),
      .o_Busy(o_Busy), .o_Valid(o_Valid), .o_Card(o_Card), .o_Suit(o_Suit),
      .o_Rank(o_Rank), .o_Value(o_Value), .o_Dealt(o_Dealt), .o_Empty(o_Empty)
   );

   always #10 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_value(int card);
      int r = card % 13 + 1;
      return (r == 1) ? 11 : (r >= 10 ? 10 : r);
   endfunction

   function automatic void model_clear();
      foreach (deck[i]) deck[i] = 0;
      ndealt = 0;
   endfunction

   always @(negedge clk_50M) begin
      if (o_Zero) begin
         if (q.size() == 0) chk("zero_unexpected", 1, 0);
         else begin
            chk("zero_cycle", cyc, q[0].zcyc);
            zseen = 1;
         end
      end
      if (o_Valid) begin
         if (q.size() == 0) chk("valid_unexpected", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("card", int'(o_Card), mon_e.card);
            chk("suit", int'(o_Suit), mon_e.card / 13);
            chk("rank", int'(o_Rank), mon_e.card % 13 + 1);
            chk("value", int'(o_Value), exp_value(mon_e.card));
            chk("dealt", int'(o_Dealt), mon_e.dealt);
            chk("empty", int'(o_Empty), int'(mon_e.dealt == 52));
            chk("valid_cycle", cyc, mon_e.vcyc);
            chk("zero_before_valid", int'(zseen), 1);
            chk("active_before_valid", int'(prev_active), 1);
            chk("active_at_valid", int'(o_Active), 0);
            chk("busy_at_valid", int'(o_Busy), 1);
            zseen = 0;
         end
      end
      prev_active = o_Active;
   end

   task automatic start_draw(input int cnt, input bit stale, output int a, output int k);
      int c;
      exp_t e;
      @(negedge clk_50M);
      i_Count = 12'(cnt);
      i_TwoSec = stale;
      i_Draw = 1'b1;
      @(posedge clk_50M);
      #1;
      i_Draw = 1'b0;
      a = cyc;
      c = cnt % 52;
      k = 0;
      while (deck[c]) begin
         c = (c + 1) % 52;
         k++;
      end
      deck[c] = 1;
      ndealt++;
      e.card = c;
      e.dealt = ndealt;
      e.zcyc = a + 2 + k;
      e.vcyc = a + ((stale || mz_lat(k) < 5 + k) ? 5 + k : mz_lat(k));
      q.push_back(e);
   endtask

   int cur_mz = 0;
   function automatic int mz_lat(int k);
      return 3 + k + cur_mz;
   endfunction

   task automatic draw(input int cnt, input int mz, input bit stale);
      int a, k, t;
      cur_mz = mz;
      start_draw(cnt, stale, a, k);
      if (!stale) begin
         repeat (2 + k + mz) @(posedge clk_50M);
         #1;
         i_TwoSec = 1'b1;
      end
      t = 0;
      while (q.size() != 0 && t < 400) begin
         @(posedge clk_50M);
         t++;
      end
      if (q.size() != 0) begin
         chk("valid_timeout", 0, 1);
         q.delete();
      end
      #1;
      i_TwoSec = 1'b0;
   endtask

   task automatic shuffle(input bit with_draw);
      @(negedge clk_50M);
      i_Shuffle = 1'b1;
      i_Draw = with_draw;
      @(posedge clk_50M);
      #1;
      i_Shuffle = 1'b0;
      i_Draw = 1'b0;
      model_clear();
      chk("shuffle_dealt", int'(o_Dealt), 0);
      chk("shuffle_empty", int'(o_Empty), 0);
      chk("shuffle_busy", int'(o_Busy), 0);
   endtask

   initial begin
      int a, k, t;
      model_clear();
      repeat (3) @(posedge clk_50M);
      #1;
      chk("reset_outputs", int'({o_Zero, o_Active, o_Busy, o_Valid, o_Empty}), 0);
      chk("reset_card", int'({o_Card, o_Suit, o_Rank, o_Value}), 0);
      chk("reset_dealt", int'(o_Dealt), 0);
      @(negedge clk_50M);
      i_Reset = 1'b0;

      draw(53, 10, 0);
      chk("t1_card", int'(o_Card), 1);
      chk("t1_value", int'(o_Value), 2);
      draw(100, 3, 0);
      chk("t2_card", int'(o_Card), 48);
      draw(48, 0, 0);
      chk("t3_card", int'(o_Card), 49);
      chk("t3_rank", int'(o_Rank), 11);
      draw(51, 1, 0);
      chk("t4_card", int'(o_Card), 51);
      draw(51, 2, 0);
      chk("t5_card", int'(o_Card), 0);
      chk("t5_value", int'(o_Value), 11);
      draw($urandom_range(0, 4095), 0, 1);

      start_draw(48, 0, a, k);
      t = 0;
      while (!o_Active && t < 200) begin
         @(posedge clk_50M);
         #1;
         t++;
      end
      chk("abort_reached_hold", int'(o_Active), 1);
      @(negedge clk_50M);
      i_Reset = 1'b1;
      q.delete();
      model_clear();
      zseen = 0;
      @(posedge clk_50M);
      #1;
      chk("abort_active", int'(o_Active), 0);
      chk("abort_busy", int'(o_Busy), 0);
      chk("abort_dealt", int'(o_Dealt), 0);
      chk("abort_valid", int'(o_Valid), 0);
      @(negedge clk_50M);
      i_Reset = 1'b0;
      i_TwoSec = 1'b1;
      repeat (5) @(posedge clk_50M);
      i_TwoSec = 1'b0;
      draw(48, 2, 0);
      chk("after_abort_card", int'(o_Card), 48);

      while (ndealt < 52) draw($urandom_range(0, 4095), 0, 1);
      chk("exhaust_empty", int'(o_Empty), 1);
      chk("exhaust_dealt", int'(o_Dealt), 52);
      @(negedge clk_50M);
      i_Draw = 1'b1;
      repeat (3) @(posedge clk_50M);
      #1;
      chk("draw_when_empty_busy", int'(o_Busy), 0);
      i_Draw = 1'b0;
      shuffle(1'b1);
      repeat (2) @(posedge clk_50M);
      #1;
      chk("shuffle_draw_dropped", int'(o_Busy), 0);

      for (int i = 0; i < 24; i++) begin
         if (i == 12) shuffle(1'b0);
         draw($urandom_range(0, 4095), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end
      repeat (4) @(posedge clk_50M);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
